spi_frame_slave: RTL and testbench

Oversampling SPI slave that sits directly upstream of the debug register bank. It deserializes host SPI frames (mode 0, MSB first) in the `clk` domain and presents a parallel address/write-data/write-strobe interface. It also returns the register bank's combinational read data serially on MISO. The debug unit consumes `spi_addr`, `spi_wdata`, `spi_wr_en` and `spi_ss_n` and supplies `spi_rdata`.

---
 rtl/spi_frame_slave.sv | 190 +++++++++++++++++++
 tb/tb_spi_frame_slave.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_slave.sv
// Oversampling SPI slave (mode 0, MSB first) feeding the debug register bank.
// Deserializes R/W + address + data frames and serializes read data on MISO.
module spi_frame_slave #(
    parameter int NB_ADDR = 7,
    parameter int NB_DATA = 8,
    parameter int WR_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sclk,
    input  logic               ss_n,
    input  logic               mosi,
    output logic               miso,
    output logic               miso_oe,
    output logic [NB_ADDR-1:0] spi_addr,
    output logic [NB_DATA-1:0] spi_wdata,
    output logic               spi_wr_en,
    output logic               spi_ss_n,
    input  logic [NB_DATA-1:0] spi_rdata,
    output logic               frame_err
);

    // state | meaning
    // IDLE  | waiting for a qualified ss_n falling edge
    // HDR   | shifting in R/W bit and address
    // DATA  | shifting in data; serializing read data on MISO for reads
    // HOLD  | spi_wr_en held high for WR_HOLD cycles
    // DONE  | frame complete, sclk ignored until ss_n rises

    localparam int FL = 1 + NB_ADDR + NB_DATA;
    localparam int CW = $clog2(FL);
    localparam int HW = $clog2(WR_HOLD + 1);

    typedef enum logic [2:0] {IDLE, HDR, DATA, HOLD, DONE} state_t;

    state_t             state;
    logic               sclk_s1, sclk_s2, sclk_d;
    logic               ss_s1, ss_d;
    logic               mosi_s1, mosi_s2;
    logic [1:0]         warm_cnt;
    logic               armed;
    logic               sclk_rise, sclk_fall, ss_fall;
    logic [NB_ADDR-1:0] hdr_sr;
    logic [NB_DATA-2:0] data_sr;
    logic [NB_DATA-1:0] tx_sr;
    logic [NB_ADDR:0]   hdr_next;
    logic [NB_DATA-1:0] data_next;
    logic               rw;
    logic               tx_load;
    logic [CW-1:0]      bit_cnt;
    logic [HW-1:0]      hold_cnt;

    // A fall is only trusted once ss_n has been seen high after reset, so a
    // select held low through reset cannot start a frame mid-stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s1  <= 1'b0;
            sclk_s2  <= 1'b0;
            sclk_d   <= 1'b0;
            ss_s1    <= 1'b1;
            spi_ss_n <= 1'b1;
            ss_d     <= 1'b1;
            mosi_s1  <= 1'b0;
            mosi_s2  <= 1'b0;
            warm_cnt <= 2'd3;
            armed    <= 1'b0;
        end else begin
            sclk_s1  <= sclk;
            sclk_s2  <= sclk_s1;
            sclk_d   <= sclk_s2;
            ss_s1    <= ss_n;
            spi_ss_n <= ss_s1;
            ss_d     <= spi_ss_n;
            mosi_s1  <= mosi;
            mosi_s2  <= mosi_s1;
            if (warm_cnt != 2'd0)
                warm_cnt <= warm_cnt - 2'd1;
            else if (spi_ss_n)
                armed <= 1'b1;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_d;
    assign sclk_fall = ~sclk_s2 & sclk_d;
    assign ss_fall   = armed & ss_d & ~spi_ss_n;
    assign hdr_next  = {hdr_sr, mosi_s2};
    assign data_next = {data_sr, mosi_s2};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hdr_sr    <= '0;
            data_sr   <= '0;
            tx_sr     <= '0;
            rw        <= 1'b0;
            tx_load   <= 1'b0;
            bit_cnt   <= '0;
            hold_cnt  <= '0;
            spi_addr  <= '0;
            spi_wdata <= '0;
            spi_wr_en <= 1'b0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            tx_load   <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    miso_oe <= 1'b0;
                    miso    <= 1'b0;
                    if (ss_fall) begin
                        state   <= HDR;
                        bit_cnt <= CW'(NB_ADDR);
                    end
                end
                HDR: begin
                    if (spi_ss_n) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                        miso_oe   <= 1'b0;
                        miso      <= 1'b0;
                    end else if (sclk_rise) begin
                        hdr_sr <= hdr_next[NB_ADDR-1:0];
                        if (bit_cnt == '0) begin
                            spi_addr <= hdr_next[NB_ADDR-1:0];
                            rw       <= hdr_next[NB_ADDR];
                            tx_load  <= 1'b1;
                            bit_cnt  <= CW'(NB_DATA - 1);
                            state    <= DATA;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end
                DATA: begin
                    miso_oe <= rw;
                    // spi_addr settled last cycle, so spi_rdata is valid now
                    if (tx_load)
                        tx_sr <= spi_rdata;
                    if (spi_ss_n) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                        miso_oe   <= 1'b0;
                        miso      <= 1'b0;
                    end else begin
                        if (sclk_fall && rw) begin
                            miso  <= tx_sr[NB_DATA-1];
                            tx_sr <= {tx_sr[NB_DATA-2:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            data_sr <= data_next[NB_DATA-2:0];
                            if (bit_cnt == '0) begin
                                if (rw) begin
                                    state <= DONE;
                                end else begin
                                    state     <= HOLD;
                                    spi_wdata <= data_next;
                                    spi_wr_en <= 1'b1;
                                    hold_cnt  <= HW'(WR_HOLD - 1);
                                end
                            end else begin
                                bit_cnt <= bit_cnt - 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        spi_wr_en <= 1'b0;
                        state     <= DONE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                DONE: begin
                    // Level test: ss_n may already have risen during HOLD
                    if (spi_ss_n) begin
                        state   <= IDLE;
                        miso_oe <= 1'b0;
                        miso    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed bench for spi_frame_slave: host SPI driver at f_clk/8 plus a
// looped-back register model on the parallel side.
module tb_spi_frame_slave;

    logic       clk, rst_n, sclk, ss_n, mosi;
    logic       miso, miso_oe, spi_wr_en, spi_ss_n, frame_err;
    logic [6:0] spi_addr;
    logic [7:0] spi_wdata, spi_rdata;

    spi_frame_slave #(.NB_ADDR(7), .NB_DATA(8), .WR_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .spi_addr(spi_addr),
        .spi_wdata(spi_wdata), .spi_wr_en(spi_wr_en), .spi_ss_n(spi_ss_n),
        .spi_rdata(spi_rdata), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rise_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // register bank model with write loopback; 0x11 defaults to 0x5C
    logic [7:0]   mem [128];
    logic [127:0] wr_valid = '0;
    always_comb spi_rdata = wr_valid[spi_addr] ? mem[spi_addr] :
                            ((spi_addr == 7'h11) ? 8'h5C : 8'h00);

    int         wr_pulses = 0, wr_start_cyc = 0, wr_len = 0, wr_run = 0;
    int         err_pulses = 0, err_len = 0, err_run = 0;
    int         oe_cycles = 0, miso_bad = 0;
    logic       wr_d = 1'b0, err_d = 1'b0;
    logic [7:0] wr_data_at_rise = '0;
    logic [6:0] wr_addr_at_rise = '0;

    always @(negedge clk) begin
        wr_d  <= spi_wr_en;
        err_d <= frame_err;
        if (spi_wr_en && !wr_d) begin
            wr_pulses       <= wr_pulses + 1;
            wr_start_cyc    <= cyc;
            wr_data_at_rise <= spi_wdata;
            wr_addr_at_rise <= spi_addr;
            mem[spi_addr]      <= spi_wdata;
            wr_valid[spi_addr] <= 1'b1;
            wr_run <= 1;
        end else if (spi_wr_en) begin
            wr_run <= wr_run + 1;
        end
        if (!spi_wr_en && wr_d) wr_len <= wr_run;
        if (frame_err && !err_d) begin
            err_pulses <= err_pulses + 1;
            err_run    <= 1;
        end else if (frame_err) begin
            err_run <= err_run + 1;
        end
        if (!frame_err && err_d) err_len <= err_run;
        if (miso_oe) oe_cycles <= oe_cycles + 1;
        if (!miso_oe && miso) miso_bad <= miso_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode-0 host: data changes while sclk low, MISO sampled as sclk rises.
    task automatic frame(input logic [31:0] bits, input int nbits, input bit start,
                         input bit stop, output logic [7:0] rx);
        int k;
        rx = '0;
        if (start) begin
            ss_n = 1'b0;
            wait_clk(4);
        end
        for (int i = nbits - 1; i >= 0; i--) begin
            k = nbits - 1 - i;
            mosi = bits[i];
            wait_clk(4);
            if (k >= 8 && k < 16) rx = {rx[6:0], miso};
            sclk = 1'b1;
            if (k == 15) last_rise_cyc = cyc;
            wait_clk(4);
            sclk = 1'b0;
        end
        if (stop) begin
            wait_clk(4);
            ss_n = 1'b1;
            wait_clk(4);
        end
    endtask

    logic [7:0] rx;
    int p0, o0;

    initial begin
        rst_n = 1'b0;
        sclk  = 1'b0;
        ss_n  = 1'b1;
        mosi  = 1'b0;
        wait_clk(3);
        check("rst_addr",   spi_addr,  0);
        check("rst_wdata",  spi_wdata, 0);
        check("rst_wr_en",  spi_wr_en, 0);
        check("rst_ss_n",   spi_ss_n,  1);
        check("rst_miso",   miso,      0);
        check("rst_oe",     miso_oe,   0);
        check("rst_err",    frame_err, 0);
        rst_n = 1'b1;
        wait_clk(8);

        // write 0x30 <- 0xA5
        o0 = oe_cycles;
        frame(32'h30A5, 16, 1, 1, rx);
        wait_clk(2);
        check("wr_pulses",  wr_pulses, 1);
        check("wr_addr",    spi_addr, 7'h30);
        check("wr_addr_r",  wr_addr_at_rise, 7'h30);
        check("wr_wdata_r", wr_data_at_rise, 8'hA5);
        check("wr_len",     wr_len, 4);
        check("wr_latency", wr_start_cyc - last_rise_cyc, 3);
        check("wr_no_oe",   oe_cycles - o0, 0);

        // read 0x11, model returns 0x5C
        o0 = oe_cycles;
        frame(32'h9100, 16, 1, 1, rx);
        check("rd_data",    rx, 8'h5C);
        check("rd_no_wr",   wr_pulses, 1);
        check("rd_oe_seen", (oe_cycles - o0) > 0, 1);
        check("rd_oe_drop", miso_oe, 0);
        check("rd_miso_0",  miso, 0);
        check("rd_no_err",  err_pulses, 0);

        // abort after 10 bits of write 0x32 <- 0xFF
        frame(32'h0CB, 10, 1, 1, rx);
        wait_clk(2);
        check("ab_err_cnt", err_pulses, 1);
        check("ab_err_len", err_len, 1);
        check("ab_no_wr",   wr_pulses, 1);
        check("ab_wdata",   spi_wdata, 8'hA5);
        frame(32'h323C, 16, 1, 1, rx);
        wait_clk(2);
        check("ab_next_wr", wr_pulses, 2);
        check("ab_next_a",  spi_addr, 7'h32);
        check("ab_next_d",  spi_wdata, 8'h3C);
        check("ab_next_ok", err_pulses, 1);

        // overlong 24-bit frame
        frame(32'h1001FF, 24, 1, 1, rx);
        wait_clk(2);
        check("ol_pulses",  wr_pulses, 3);
        check("ol_wdata",   spi_wdata, 8'h01);
        check("ol_addr",    spi_addr, 7'h10);
        check("ol_len",     wr_len, 4);

        // reset after 12 bits of write 0x38 <- 0x7E
        frame(32'h387, 12, 1, 0, rx);
        rst_n = 1'b0;
        #1;
        check("mr_addr",    spi_addr,  0);
        check("mr_wdata",   spi_wdata, 0);
        check("mr_wr_en",   spi_wr_en, 0);
        check("mr_ss_n",    spi_ss_n,  1);
        check("mr_oe",      miso_oe,   0);
        check("mr_err",     frame_err, 0);
        wait_clk(3);
        rst_n = 1'b1;
        frame(32'hE, 4, 0, 1, rx);
        wait_clk(2);
        check("mr_no_wr",   wr_pulses, 3);
        check("mr_no_err",  err_pulses, 1);
        frame(32'h387E, 16, 1, 1, rx);
        wait_clk(2);
        check("mr_wr_ok",   wr_pulses, 4);
        check("mr_addr2",   spi_addr, 7'h38);
        check("mr_wdata2",  spi_wdata, 8'h7E);

        // back-to-back: write 0x31 <- 0x11, then read it back
        p0 = wr_pulses;
        frame(32'h3111, 16, 1, 1, rx);
        frame(32'hB100, 16, 1, 1, rx);
        check("bb_wr",      wr_pulses - p0, 1);
        check("bb_rd",      rx, 8'h11);
        check("miso_quiet", miso_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
